// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared definitions for the SRAM controller slice.
//   - FSM state encoding (state_t and St* constants)
//   - default wait-state timing (RD_WAIT_DEF, WR_WAIT_DEF)
//   - SRAM data width (SRAM_DATA_W)
//   - helper functions used by the controller and the optional counter bank
package sram_ctrl_pkg;

  localparam int unsigned SRAM_DATA_W = 16;
  localparam int unsigned RD_WAIT_DEF = 2;
  localparam int unsigned WR_WAIT_DEF = 2;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StRd     = 3'd1;
  localparam state_t StWr     = 3'd2;
  localparam state_t StWrHold = 3'd3;
  localparam state_t StDone   = 3'd4;

  // True while the SRAM is selected (chip enable asserted).
  function automatic logic state_busy(state_t s);
    return (s == StRd) || (s == StWr) || (s == StWrHold);
  endfunction

  // 32-bit increment that sticks at all-ones.
  function automatic logic [31:0] sat_inc(logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sram_perf_cnt.sv
// sram_perf_cnt: saturating performance counter bank for sram_ctrl.
// Only instantiated when SRAM_PERF_CNT_EN is defined.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   cnt_clr       - synchronous clear of all counters (wins over increments)
//   rd_inc        - pulse: a read completed
//   wr_inc        - pulse: a write completed
//   stall_inc     - level: CPU is stalled this cycle
//   rd_cnt, wr_cnt, stall_cnt - 32-bit saturating counts
module sram_perf_cnt
  import sram_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cnt_clr,
  input  logic        rd_inc,
  input  logic        wr_inc,
  input  logic        stall_inc,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt,
  output logic [31:0] stall_cnt
);

  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr) begin
      rd_cnt_d    = 32'd0;
      wr_cnt_d    = 32'd0;
      stall_cnt_d = 32'd0;
    end else begin
      if (rd_inc)    rd_cnt_d    = sat_inc(rd_cnt_q);
      if (wr_inc)    wr_cnt_d    = sat_inc(wr_cnt_q);
      if (stall_inc) stall_cnt_d = sat_inc(stall_cnt_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q    <= 32'd0;
      wr_cnt_q    <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: single-word CPU data port to asynchronous 16-bit SRAM bridge with
// programmable wait states. Writes take priority when re and we are both set.
// Optional feature macro: SRAM_PERF_CNT_EN (adds cnt_clr, rd_cnt, wr_cnt, stall_cnt).
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   addr, re, we, wdata - CPU request (addr/wdata held while stall=1)
//   rdata               - last completed read data
//   stall               - holds the CPU pipeline during an access (combinational)
//   sram_addr           - SRAM word address (CPU address zero-extended)
//   sram_dq_o/_oe/_i    - split SRAM data bus; tristate is resolved above this block
//   sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n - active-low SRAM controls
// All SRAM pins are registered, computed from the next state.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned RD_WAIT = RD_WAIT_DEF,
  parameter int unsigned WR_WAIT = WR_WAIT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            addr,
  input  logic                   re,
  input  logic                   we,
  input  logic [15:0]            wdata,
  output logic [15:0]            rdata,
  output logic                   stall,
  output logic [ADDR_W-1:0]      sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_o,
  output logic                   sram_dq_oe,
  input  logic [SRAM_DATA_W-1:0] sram_dq_i,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n,
  output logic                   sram_ub_n,
  output logic                   sram_lb_n
`ifdef SRAM_PERF_CNT_EN
  ,
  input  logic                   cnt_clr,
  output logic [31:0]            rd_cnt,
  output logic [31:0]            wr_cnt,
  output logic [31:0]            stall_cnt
`endif
);

  // Counter is loaded with WAIT-1 so the state lasts exactly WAIT cycles.
  localparam logic [3:0] RdLoad = 4'(RD_WAIT - 1);
  localparam logic [3:0] WrLoad = 4'(WR_WAIT - 1);

  state_t                 state_q, state_d;
  logic [3:0]             wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [SRAM_DATA_W-1:0] dq_o_q, dq_o_d;
  logic [15:0]            rdata_q, rdata_d;
  logic                   dq_oe_q, dq_oe_d;
  logic                   ce_n_q, ce_n_d;
  logic                   oe_n_q, oe_n_d;
  logic                   we_n_q, we_n_d;
  logic                   bsel_n_q, bsel_n_d;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    dq_o_d     = dq_o_q;
    rdata_d    = rdata_q;

    case (state_q)
      StIdle: begin
        if (we) begin
          state_d    = StWr;
          wait_cnt_d = WrLoad;
          addr_d     = ADDR_W'(addr);
          dq_o_d     = wdata;
        end else if (re) begin
          state_d    = StRd;
          wait_cnt_d = RdLoad;
          addr_d     = ADDR_W'(addr);
        end
      end
      StRd: begin
        if (wait_cnt_q == 4'd0) begin
          // oe_n has been low for RD_WAIT cycles: data is valid now.
          rdata_d = sram_dq_i;
          state_d = StDone;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      StWr: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = StWrHold;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      StWrHold: state_d = StDone;
      // A request still present here is only seen again once back in idle.
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // Pins follow the next state so they change on the same edge as the state.
    ce_n_d   = !state_busy(state_d);
    bsel_n_d = !state_busy(state_d);
    oe_n_d   = (state_d != StRd);
    we_n_d   = (state_d != StWr);
    dq_oe_d  = (state_d == StWr) || (state_d == StWrHold);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      wait_cnt_q <= 4'd0;
      addr_q     <= '0;
      dq_o_q     <= '0;
      rdata_q    <= 16'd0;
      dq_oe_q    <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      bsel_n_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      dq_o_q     <= dq_o_d;
      rdata_q    <= rdata_d;
      dq_oe_q    <= dq_oe_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      bsel_n_q   <= bsel_n_d;
    end
  end

  assign stall      = ((state_q == StIdle) && (re || we)) || state_busy(state_q);
  assign rdata      = rdata_q;
  assign sram_addr  = addr_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_ub_n  = bsel_n_q;
  assign sram_lb_n  = bsel_n_q;

`ifdef SRAM_PERF_CNT_EN
  logic rd_done;
  logic wr_done;

  assign rd_done = (state_q == StRd) && (state_d == StDone);
  assign wr_done = (state_q == StWrHold) && (state_d == StDone);

  sram_perf_cnt u_perf_cnt (
    .clk       (clk),
    .rst       (rst),
    .cnt_clr   (cnt_clr),
    .rd_inc    (rd_done),
    .wr_inc    (wr_done),
    .stall_inc (stall),
    .rd_cnt    (rd_cnt),
    .wr_cnt    (wr_cnt),
    .stall_cnt (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed self-checking bench for sram_ctrl with a behavioural
// SRAM model, a read-data scoreboard and a pin-level protocol monitor.
module tb_sram_ctrl;

  localparam int unsigned ADDR_W  = 18;
  localparam int unsigned RD_WAIT = 2;
  localparam int unsigned WR_WAIT = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [15:0]       addr = '0;
  logic              re = 1'b0;
  logic              we = 1'b0;
  logic [15:0]       wdata = '0;
  logic [15:0]       rdata;
  logic              stall;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_dq_o;
  logic              sram_dq_oe;
  logic [15:0]       sram_dq_i;
  logic              sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
`ifdef SRAM_PERF_CNT_EN
  logic              cnt_clr = 1'b0;
  logic [31:0]       rd_cnt, wr_cnt, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  sram_ctrl #(
    .ADDR_W  (ADDR_W),
    .RD_WAIT (RD_WAIT),
    .WR_WAIT (WR_WAIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .re         (re),
    .we         (we),
    .wdata      (wdata),
    .rdata      (rdata),
    .stall      (stall),
    .sram_addr  (sram_addr),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_i  (sram_dq_i),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .sram_ub_n  (sram_ub_n),
    .sram_lb_n  (sram_lb_n)
`ifdef SRAM_PERF_CNT_EN
    ,
    .cnt_clr    (cnt_clr),
    .rd_cnt     (rd_cnt),
    .wr_cnt     (wr_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // SRAM model: 64K words, write sampled while ce_n/we_n low at each edge.
  logic [15:0] mem [0:65535];
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[15:0]] : 16'hDEAD;

  always @(posedge clk) begin
    if (!rst && !sram_ce_n && !sram_we_n) mem[sram_addr[15:0]] <= sram_dq_o;
  end

  // Protocol monitor
  int          oe_lo, we_lo, hold_cyc, rd_starts, wr_starts, viol;
  logic        prev_oe_n = 1'b1;
  logic        prev_we_n = 1'b1;
  logic [15:0] cur_wdata = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (!sram_oe_n) oe_lo++;
      if (!sram_we_n) we_lo++;
      if (!sram_ce_n && sram_we_n && sram_dq_oe) hold_cyc++;
      if (prev_oe_n && !sram_oe_n) rd_starts++;
      if (prev_we_n && !sram_we_n) wr_starts++;
      if (!sram_oe_n && !sram_we_n) viol++;
      if (sram_dq_oe && !sram_oe_n) viol++;
      if (sram_dq_oe && (sram_dq_o !== cur_wdata)) viol++;
      if (sram_ub_n !== sram_ce_n || sram_lb_n !== sram_ce_n) viol++;
    end
    prev_oe_n = sram_oe_n;
    prev_we_n = sram_we_n;
  end

  task automatic clr_mon();
    oe_lo = 0; we_lo = 0; hold_cyc = 0; rd_starts = 0; wr_starts = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Read-data scoreboard
  logic [15:0] exp_q [$];

  task automatic sb_pop(input string tag);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, {16'd0, rdata}, {16'd0, e});
    end
  endtask

  // Issues one request from idle and returns at the first cycle with stall=0
  // (DONE), or one cycle later when hold is set.
  task automatic access(input logic w, input logic r, input logic [15:0] a,
                        input logic [15:0] d, input bit hold, output int ncyc);
    @(posedge clk); #1;
    clr_mon();
    addr = a; wdata = d; we = w; re = r;
    if (w) cur_wdata = d;
    ncyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall) break;
      ncyc++;
    end
    if (hold) begin
      @(posedge clk); #1;
    end
    re = 1'b0; we = 1'b0;
  endtask

  int n;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0042] = 16'hBEEF;

    // Reset state
    #12;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_ce_n", {31'd0, sram_ce_n}, 32'd1);
    check("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
    check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("rst_rdata", {16'd0, rdata}, 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Read 0x0042
    exp_q.push_back(16'hBEEF);
    access(1'b0, 1'b1, 16'h0042, 16'h0000, 1'b0, n);
    check("rd_stall_cycles", n, RD_WAIT + 1);
    check("rd_oe_cycles", oe_lo, RD_WAIT);
    check("rd_no_we", we_lo, 0);
    check("rd_done_stall", {31'd0, stall}, 32'd0);
    sb_pop("rd_data");
    check("rd_sram_addr", 32'(sram_addr), 32'h0_0042);

    // Write 0x1234 <- 0xA5A5
    access(1'b1, 1'b0, 16'h1234, 16'hA5A5, 1'b0, n);
    check("wr_stall_cycles", n, WR_WAIT + 2);
    check("wr_we_cycles", we_lo, WR_WAIT);
    check("wr_hold_cycles", hold_cyc, 1);
    check("wr_no_oe", oe_lo, 0);
    check("wr_mem", {16'd0, mem[16'h1234]}, 32'h0000_A5A5);
    check("wr_sram_addr", 32'(sram_addr), 32'h0_1234);
    check("wr_rdata_held", {16'd0, rdata}, 32'h0000_BEEF);

    // Back-to-back write then read of 0x0010, re held through DONE
    access(1'b1, 1'b0, 16'h0010, 16'hC3C3, 1'b0, n);
    check("b2b_wr_count", wr_starts, 1);
    exp_q.push_back(16'hC3C3);
    access(1'b0, 1'b1, 16'h0010, 16'h0000, 1'b1, n);
    check("b2b_rd_stall_cycles", n, RD_WAIT + 1);
    sb_pop("b2b_rd_data");
    repeat (3) @(negedge clk);
    check("b2b_rd_count", rd_starts, 1);
    check("b2b_no_wr", wr_starts, 0);
    check("b2b_idle_stall", {31'd0, stall}, 32'd0);

    // re and we together: write wins
    access(1'b1, 1'b1, 16'h0005, 16'h5A5A, 1'b0, n);
    check("rw_stall_cycles", n, WR_WAIT + 2);
    check("rw_no_oe", oe_lo, 0);
    check("rw_wr_count", wr_starts, 1);
    check("rw_mem", {16'd0, mem[16'h0005]}, 32'h0000_5A5A);

    // Reset during the second WR cycle
    @(posedge clk); #1;
    cur_wdata = 16'h7777; addr = 16'h0100; wdata = 16'h7777; we = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; we = 1'b0; re = 1'b0;
    #1;
    check("arst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("arst_ce_n", {31'd0, sram_ce_n}, 32'd1);
    check("arst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("arst_stall", {31'd0, stall}, 32'd0);
    check("arst_rdata", {16'd0, rdata}, 32'd0);
    check("arst_addr", 32'(sram_addr), 32'd0);
    @(negedge clk); rst = 1'b0;

`ifdef SRAM_PERF_CNT_EN
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(16'hBEEF);
      access(1'b0, 1'b1, 16'h0042, 16'h0000, 1'b0, n);
      sb_pop("perf_rd_data");
    end
    for (int i = 0; i < 2; i++) begin
      access(1'b1, 1'b0, 16'h0200 + 16'(i), 16'h1100 + 16'(i), 1'b0, n);
    end
    check("perf_rd_cnt", rd_cnt, 32'd3);
    check("perf_wr_cnt", wr_cnt, 32'd2);
    check("perf_stall_cnt", stall_cnt, 32'd17);
    @(posedge clk); #1;
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    check("perf_clr_rd", rd_cnt, 32'd0);
    check("perf_clr_wr", wr_cnt, 32'd0);
    check("perf_clr_stall", stall_cnt, 32'd0);
`endif

    check("protocol_viol", viol, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Sits directly downstream of the CPU's external data-memory port.
- Accepts single-word read and write requests (addr/re/we/wdata) and drives an asynchronous 16-bit SRAM with programmable wait states.
- Returns read data and a stall to hold the CPU pipeline for the duration of each access.
- The SRAM data tristate is resolved at top level; this block exposes a split in/out/oe data bus.

Parameters:
- ADDR_W, 18, SRAM word-address width; CPU address is zero-extended into it.
- RD_WAIT, 2, cycles oe_n is held low before read data is captured (legal range 1..15).
- WR_WAIT, 2, cycles we_n is held low per write (legal range 1..15).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- addr  input  16  CPU word address; held stable while stall=1.
- re  input  1  CPU read request.
- we  input  1  CPU write request.
- wdata  input  16  CPU write data.
- rdata  output  16  read data; valid in DONE and held until the next read completes.
- stall  output  1  holds the CPU pipeline while an access is in progress.
- sram_addr  output  ADDR_W  SRAM address pins.
- sram_dq_o  output  16  data to SRAM.
- sram_dq_oe  output  1  top-level tristate enable for sram_dq_o.
- sram_dq_i  input  16  data from SRAM.
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  output  1 each  SRAM controls, active-low.

Behaviour:
- FSM states: IDLE, RD, WR, WR_HOLD, DONE. A 4-bit wait counter is loaded on entry to RD or WR.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All *_n outputs go to 1; sram_dq_oe=0; sram_addr=0; sram_dq_o=0; rdata=0; counter=0.
  - An access in progress is aborted with no completion.
- All SRAM pins are registered outputs. stall is combinational: stall = (IDLE & (re|we)) | (state in RD, WR, WR_HOLD).
- IDLE:
  - If we=1 (write has priority when re and we are both 1): latch addr and wdata, go to WR.
  - Else if re=1: latch addr, go to RD.
  - Else stay in IDLE.
- RD:
  - Outputs: ce_n=0, oe_n=0, ub_n=lb_n=0, dq_oe=0.
  - Held for RD_WAIT cycles. On the last cycle, sram_dq_i is registered into rdata. Then go to DONE.
- WR:
  - Outputs: ce_n=0, we_n=0, ub_n=lb_n=0, dq_oe=1, dq_o=latched wdata.
  - Held for WR_WAIT cycles, then go to WR_HOLD.
- WR_HOLD:
  - One cycle with we_n=1, ce_n=0, dq_oe=1 and data still driven (data hold time). Then go to DONE.
- DONE:
  - All controls deasserted; stall=0; the CPU advances.
  - Unconditionally return to IDLE. A request still asserted in DONE is not re-accepted until IDLE.
- Latency in stall cycles: read = RD_WAIT+1; write = WR_WAIT+2. Minimum turnaround between accesses is 1 idle cycle (DONE).
- sram_oe_n and sram_we_n are never low in the same cycle. dq_oe is never 1 while oe_n=0.

Optional Feature:
- Macro: SRAM_PERF_CNT_EN.
- With the macro defined:
  - Adds outputs rd_cnt[31:0], wr_cnt[31:0] and stall_cnt[31:0], plus input cnt_clr.
  - rd_cnt/wr_cnt increment on entry to DONE from RD / WR_HOLD respectively.
  - stall_cnt increments every cycle stall=1.
  - All three saturate at 0xFFFFFFFF.
  - cnt_clr (synchronous) and rst zero all three; clear wins over increment in the same cycle.
- Without the macro: the ports and logic are absent, and core behaviour is identical.

Decomposition:
- Package sram_ctrl_pkg holds:
  - the state enum (IDLE, RD, WR, WR_HOLD, DONE);
  - default timing constants RD_WAIT_DEF=2 and WR_WAIT_DEF=2;
  - the SRAM data width constant of 16.
- One sub-module, sram_perf_cnt: the saturating counter bank, instantiated only under SRAM_PERF_CNT_EN.
- The FSM and wait counter stay in sram_ctrl.

Test Plan:
- Read, RD_WAIT=2: re=1, addr=0x0042, SRAM model returns 0xBEEF -> stall=1 for 3 cycles; oe_n=0 for 2 cycles; rdata=0xBEEF in DONE with stall=0; sram_addr=0x00042.
- Write, WR_WAIT=2: we=1, addr=0x1234, wdata=0xA5A5 -> we_n low 2 cycles then high 1 cycle with dq_oe=1 and dq_o=0xA5A5 throughout; stall=1 for 4 cycles; model holds 0xA5A5 at 0x01234.
- Back-to-back write to 0x0010 then read of 0x0010, re held through DONE -> exactly one write and one read, separated by the IDLE cycle; read returns the written value; no duplicate access.
- re=we=1 on addr 0x0005 -> write performed, no oe_n pulse, stall length WR_WAIT+2.
- rst asserted during the second WR cycle -> same edge: we_n=1, ce_n=1, dq_oe=0, state IDLE, stall=0 with re=we=0; rdata=0.
- With SRAM_PERF_CNT_EN: 3 reads, 2 writes, RD_WAIT=WR_WAIT=2 -> rd_cnt=3, wr_cnt=2, stall_cnt=17; cnt_clr -> all zero next cycle.
